// File: rtl/popcount_stream_if.sv
// AXI4-Stream slave bundle for popcount_stream: data, byte keep, last,
// valid/ready handshake. DATA_WIDTH must match the attached block.
interface popcount_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA;
  logic [DATA_WIDTH/8-1:0] S_AXIS_TKEEP;
  logic                    S_AXIS_TLAST;
  logic                    S_AXIS_TVALID;
  logic                    S_AXIS_TREADY;

  modport master (
    output S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST, S_AXIS_TVALID,
    input  S_AXIS_TREADY
  );

  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST, S_AXIS_TVALID,
    output S_AXIS_TREADY
  );
endinterface

// File: rtl/popcount_stream.sv
// Pipelined stream popcount. Counts set bits of TKEEP-masked stream beats
// and of 32-bit MMIO write words into a running total (COUNT), and keeps a
// per-packet stream count latched on TLAST (LAST_PKT_COUNT).
// Pipeline: S1 masks and registers, S2 computes popcounts, then accumulate.
// Optional build macro POPCOUNT_SATURATE_EN: counters clamp at all-ones
// instead of wrapping.
module popcount_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   S_AXIS_ACLK,
  input  logic                   S_AXIS_ARESET,
  popcount_stream_if.slave       s_axis,
  input  logic [31:0]            WRITE_DATA,
  input  logic                   WRITE_VALID,
  output logic [COUNT_WIDTH-1:0] COUNT,
  input  logic                   COUNT_RST,
  output logic                   COUNT_BUSY,
  output logic [COUNT_WIDTH-1:0] LAST_PKT_COUNT,
  output logic                   LAST_PKT_VALID
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int SUM_WIDTH  = $clog2(DATA_WIDTH + 1);
  // Accumulation is done wide enough that one beat plus one word can never
  // overflow before clamping/wrapping, even for narrow COUNT_WIDTH.
  localparam int EXT_WIDTH  = COUNT_WIDTH + SUM_WIDTH + 2;

  typedef logic [COUNT_WIDTH-1:0] cnt_t;
  typedef logic [EXT_WIDTH-1:0]   ext_t;

  logic                  clear;
  logic                  accept_en;
  logic [DATA_WIDTH-1:0] masked;

  // S1 registers
  logic [DATA_WIDTH-1:0] d1;
  logic                  last1;
  logic                  v1s;
  logic [31:0]           wdata1;
  logic                  v1w;

  // S2 registers
  logic [SUM_WIDTH-1:0]  ssum2;
  logic [5:0]            wsum2;
  logic                  last2;
  logic                  v2s;
  logic                  v2w;

  // Accumulators
  cnt_t count_q;
  cnt_t pkt_q;
  cnt_t last_pkt_q;
  logic last_pkt_valid_q;

  ext_t add_s;
  ext_t add_w;
  ext_t count_sum;
  ext_t pkt_sum;

  assign clear     = S_AXIS_ARESET || COUNT_RST;
  assign accept_en = !clear;
  assign s_axis.S_AXIS_TREADY = accept_en;

  function automatic logic [SUM_WIDTH-1:0] ones_beat(input logic [DATA_WIDTH-1:0] d);
    logic [SUM_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) c = c + SUM_WIDTH'(d[i]);
    return c;
  endfunction

  function automatic logic [5:0] ones_word(input logic [31:0] d);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(d[i]);
    return c;
  endfunction

  // Saturating or wrapping reduction of a wide sum to counter width.
  function automatic cnt_t fold(input ext_t v);
`ifdef POPCOUNT_SATURATE_EN
    cnt_t cnt_max;
    cnt_max = '1;
    return (v > EXT_WIDTH'(cnt_max)) ? cnt_max : cnt_t'(v);
`else
    return cnt_t'(v);
`endif
  endfunction

  // Zero every byte whose TKEEP bit is clear.
  always_comb begin
    // NOTE: default first so every path assigns masked and no latch is inferred.
    masked = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (s_axis.S_AXIS_TKEEP[i]) masked[8*i +: 8] = s_axis.S_AXIS_TDATA[8*i +: 8];
    end
  end

  // S1: register masked beat, write word and their valids.
  always_ff @(posedge S_AXIS_ACLK) begin
    // NOTE: payload registers are not reset; only the valid flags qualify them.
    // NOTE: non-blocking assignments so all stages update from pre-edge values.
    d1     <= masked;
    last1  <= s_axis.S_AXIS_TLAST;
    wdata1 <= WRITE_DATA;
    if (clear) begin
      v1s <= 1'b0;
      v1w <= 1'b0;
    end else begin
      v1s <= s_axis.S_AXIS_TVALID && accept_en;
      v1w <= WRITE_VALID;
    end
  end

  // S2: popcounts of the stage-1 payloads.
  always_ff @(posedge S_AXIS_ACLK) begin
    ssum2 <= ones_beat(d1);
    wsum2 <= ones_word(wdata1);
    last2 <= last1;
    if (clear) begin
      v2s <= 1'b0;
      v2w <= 1'b0;
    end else begin
      v2s <= v1s;
      v2w <= v1w;
    end
  end

  // Next accumulator values computed at extended width.
  always_comb begin
    add_s     = v2s ? EXT_WIDTH'(ssum2) : '0;
    add_w     = v2w ? EXT_WIDTH'(wsum2) : '0;
    count_sum = EXT_WIDTH'(count_q) + add_s + add_w;
    pkt_sum   = EXT_WIDTH'(pkt_q) + add_s;
  end

  // Accumulate: running total, packet sum, and packet result on TLAST.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (clear) begin
      count_q          <= '0;
      pkt_q            <= '0;
      last_pkt_q       <= '0;
      last_pkt_valid_q <= 1'b0;
    end else begin
      last_pkt_valid_q <= 1'b0;
      if (v2s || v2w) count_q <= fold(count_sum);
      if (v2s) begin
        if (last2) begin
          last_pkt_q       <= fold(pkt_sum);
          last_pkt_valid_q <= 1'b1;
          pkt_q            <= '0;
        end else begin
          pkt_q <= fold(pkt_sum);
        end
      end
    end
  end

  assign COUNT          = count_q;
  assign LAST_PKT_COUNT = last_pkt_q;
  assign LAST_PKT_VALID = last_pkt_valid_q;
  assign COUNT_BUSY     = v1s | v1w | v2s | v2w;

endmodule

// File: tb/tb_popcount_stream.sv
// Randomised and directed bench for popcount_stream. Two instances share the
// stimulus: a 64/32 build for functional totals and a 64/8 build that
// exercises counter overflow (wrap, or clamp with POPCOUNT_SATURATE_EN).
module tb_popcount_stream;

  localparam int DW = 64;

  logic        clk = 1'b0;
  logic        areset;
  logic        count_rst;
  logic [DW-1:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic [31:0] wdata;
  logic        wvalid;

  logic [31:0] count_w, last_w;
  logic        busy_w, lvalid_w;
  logic [7:0]  count_n, last_n;
  logic        busy_n, lvalid_n;

  popcount_stream_if #(.DATA_WIDTH(DW)) axis_w ();
  popcount_stream_if #(.DATA_WIDTH(DW)) axis_n ();

  assign axis_w.S_AXIS_TDATA  = tdata;
  assign axis_w.S_AXIS_TKEEP  = tkeep;
  assign axis_w.S_AXIS_TLAST  = tlast;
  assign axis_w.S_AXIS_TVALID = tvalid;
  assign axis_n.S_AXIS_TDATA  = tdata;
  assign axis_n.S_AXIS_TKEEP  = tkeep;
  assign axis_n.S_AXIS_TLAST  = tlast;
  assign axis_n.S_AXIS_TVALID = tvalid;

  popcount_stream #(.DATA_WIDTH(DW), .COUNT_WIDTH(32)) u_dut_w (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(areset), .s_axis(axis_w),
    .WRITE_DATA(wdata), .WRITE_VALID(wvalid), .COUNT(count_w),
    .COUNT_RST(count_rst), .COUNT_BUSY(busy_w),
    .LAST_PKT_COUNT(last_w), .LAST_PKT_VALID(lvalid_w)
  );

  popcount_stream #(.DATA_WIDTH(DW), .COUNT_WIDTH(8)) u_dut_n (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(areset), .s_axis(axis_n),
    .WRITE_DATA(wdata), .WRITE_VALID(wvalid), .COUNT(count_n),
    .COUNT_RST(count_rst), .COUNT_BUSY(busy_n),
    .LAST_PKT_COUNT(last_n), .LAST_PKT_VALID(lvalid_n)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted item becomes visible two edges later.
  typedef struct {
    int due;
    int ssum;
    int wsum;
    bit beat;
    bit wr;
    bit last;
  } item_t;

  item_t  pend[$];
  int     cyc = 0;
  longint m_total = 0;
  longint m_pkt = 0;
  longint m_last = 0;
  bit     m_pulse = 0;

  function automatic longint fold(input longint v, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
`ifdef POPCOUNT_SATURATE_EN
    return (v > lim) ? lim : v;
`else
    return v & lim;
`endif
  endfunction

  function automatic int kept_ones(input logic [DW-1:0] d, input logic [7:0] k);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (k[i]) n += $countones(d[8*i +: 8]);
    return n;
  endfunction

  // One clock cycle: drive inputs, advance the model at the edge, compare.
  task automatic step(input bit v, input logic [DW-1:0] d, input logic [7:0] k,
                      input bit l, input bit wv, input logic [31:0] wd,
                      input bit cr, input bit ar);
    item_t it;
    tvalid = v; tdata = d; tkeep = k; tlast = l;
    wvalid = wv; wdata = wd; count_rst = cr; areset = ar;
    #1;
    check("tready", axis_w.S_AXIS_TREADY, !(ar || cr));
    @(posedge clk);
    cyc++;
    if (ar || cr) begin
      pend.delete();
      m_total = 0; m_pkt = 0; m_last = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        it = pend.pop_front();
        if (it.beat) m_total += it.ssum;
        if (it.wr)   m_total += it.wsum;
        if (it.beat) begin
          m_pkt += it.ssum;
          if (it.last) begin
            m_last = m_pkt; m_pulse = 1; m_pkt = 0;
          end
        end
      end
      if (v || wv) begin
        it.due = cyc + 2; it.ssum = kept_ones(d, k); it.wsum = $countones(wd);
        it.beat = v; it.wr = wv; it.last = l;
        pend.push_back(it);
      end
    end
    @(negedge clk);
    check("count_w",  count_w,  fold(m_total, 32));
    check("count_n",  count_n,  fold(m_total, 8));
    check("last_w",   last_w,   fold(m_last, 32));
    check("last_n",   last_n,   fold(m_last, 8));
    check("lvalid_w", lvalid_w, m_pulse);
    check("lvalid_n", lvalid_n, m_pulse);
    check("busy_w",   busy_w,   pend.size() != 0);
    check("busy_n",   busy_n,   pend.size() != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, '0, 0, 0);
  endtask

  task automatic clr();
    step(0, '0, '0, 0, 0, '0, 1, 0);
  endtask

  initial begin
    logic [DW-1:0] ones;
    ones = '1;

    // Reset held three cycles, then released.
    for (int i = 0; i < 3; i++) step(1, ones, 8'hFF, 1, 1, 32'hFFFF_FFFF, 0, 1);
    idle(1);

    // Masked beat: low four bytes only.
    step(1, ones, 8'h0F, 1, 0, '0, 0, 0);
    idle(2);
    check("masked_cnt", count_w, 32);
    check("masked_pkt", last_w, 32);

    // Four full beats plus an MMIO word on beat 2.
    clr();
    step(1, ones, 8'hFF, 0, 0, '0, 0, 0);
    step(1, ones, 8'hFF, 0, 1, 32'h0000_000F, 0, 0);
    step(1, ones, 8'hFF, 0, 0, '0, 0, 0);
    step(1, ones, 8'hFF, 1, 0, '0, 0, 0);
    idle(2);
    check("mixed_cnt", count_w, 260);
    check("mixed_pkt", last_w, 256);

    // Two packets.
    clr();
    step(1, 64'h7,  8'hFF, 0, 0, '0, 0, 0);
    step(1, 64'h1F, 8'hFF, 1, 0, '0, 0, 0);
    step(1, 64'h7F, 8'hFF, 1, 0, '0, 0, 0);
    idle(2);
    check("two_cnt", count_w, 15);
    check("two_pkt", last_w, 7);

    // COUNT_RST cuts two in-flight beats.
    clr();
    step(1, 64'hFF,  8'hFF, 0, 0, '0, 0, 0);
    step(1, 64'hFF0, 8'hFF, 1, 1, 32'hF, 0, 0);
    step(1, ones,    8'hFF, 1, 1, 32'hF, 1, 0);
    idle(2);
    check("crst_cnt", count_w, 0);
    check("crst_busy", busy_w, 0);
    check("crst_pkt", last_w, 0);
    step(1, 64'hF, 8'hFF, 1, 0, '0, 0, 0);
    idle(2);
    check("crst_after", count_w, 4);

    // Zero keep mask still closes a packet.
    clr();
    step(1, ones, 8'h00, 1, 0, '0, 0, 0);
    idle(2);
    check("zkeep_cnt", count_w, 0);

    // Overflow of the 8-bit instance: 320 set bits.
    clr();
    for (int i = 0; i < 5; i++) step(1, ones, 8'hFF, 0, 0, '0, 0, 0);
    idle(2);
    check("ovf_wide", count_w, 320);
`ifdef POPCOUNT_SATURATE_EN
    check("ovf_narrow", count_n, 255);
`else
    check("ovf_narrow", count_n, 64);
`endif

    // Randomised traffic with occasional clears and resets.
    clr();
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] d;
      logic [7:0] k;
      d = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: k = 8'hFF;
        1: k = 8'h00;
        default: k = 8'($urandom());
      endcase
      step($urandom_range(0, 3) != 0, d, k, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom(),
           $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/popcount_stream.md
# popcount_stream

Parametrised, pipelined successor to the 32-bit stream popcount. It counts set bits on an AXI4-Stream slave of configurable width, honouring TKEEP byte masking, and also counts the 32-bit MMIO write word. It keeps a running total plus a per-packet count that is latched on TLAST. It sits between the DMA MM2S stream and the MMIO register block, where COUNT, COUNT_BUSY and the packet result are readable.

## Interface
Parameters:
- DATA_WIDTH, 32: stream data width in bits. Must be a multiple of 32, range 32..256.
- COUNT_WIDTH, 32: width of the COUNT and LAST_PKT_COUNT accumulators. Range 8..64.

Ports:
- S_AXIS_ACLK  in  1  single clock; everything is on its rising edge.
- S_AXIS_ARESET  in  1  synchronous, active-high reset.
- S_AXIS_TDATA  in  DATA_WIDTH  stream data.
- S_AXIS_TKEEP  in  DATA_WIDTH/8  byte qualifiers; bit i masks TDATA[8i+7:8i].
- S_AXIS_TLAST  in  1  end of packet.
- S_AXIS_TVALID  in  1  beat valid.
- S_AXIS_TREADY  out  1  beat ready.
- WRITE_DATA  in  32  MMIO word to be counted.
- WRITE_VALID  in  1  one-cycle qualifier for WRITE_DATA.
- COUNT  out  COUNT_WIDTH  running total of set bits (stream plus MMIO).
- COUNT_RST  in  1  synchronous clear of all counts and the pipeline.
- COUNT_BUSY  out  1  high while any accepted data has not yet reached COUNT.
- LAST_PKT_COUNT  out  COUNT_WIDTH  set-bit count of the most recently completed packet (stream only).
- LAST_PKT_VALID  out  1  one-cycle pulse when LAST_PKT_COUNT updates.

## Operation
- Beat accept: TVALID && TREADY at a rising edge. TREADY = !S_AXIS_ARESET && !COUNT_RST. There is no other backpressure, so the pipeline never stalls.
- MMIO accept: WRITE_VALID at a rising edge while COUNT_RST is low. WRITE_VALID is ignored during COUNT_RST or reset.
- Pipeline stage S1 (registered):
  - Masked data = TDATA with unkept bytes zeroed.
  - Latched alongside it: TLAST, beat valid v1s, WRITE_DATA and write valid v1w.
- Pipeline stage S2 (registered):
  - Stream sum = popcount of the masked data.
  - Write sum = popcount of WRITE_DATA.
  - Latched alongside: valids v2s, v2w and the last flag.
  - Sum widths are $clog2(DATA_WIDTH+1) and 6 bits, zero-extended to COUNT_WIDTH before accumulation.
- Accumulate (at each edge where S2 is valid):
  - COUNT += (v2s ? stream sum : 0) + (v2w ? write sum : 0).
  - Internal packet sum PKT += (v2s ? stream sum : 0).
  - If v2s && last: LAST_PKT_COUNT <= PKT + stream sum, LAST_PKT_VALID pulses for one cycle, PKT <= 0.
- Simultaneous beat and MMIO write in one cycle: both are counted in the same accumulation. MMIO bits never enter PKT.
- COUNT_BUSY = v1s | v1w | v2s | v2w (registered flags, OR'd combinationally).
- Priority: S_AXIS_ARESET > COUNT_RST > accumulate.
- COUNT_RST clears all valids, COUNT, PKT, LAST_PKT_COUNT and LAST_PKT_VALID. In-flight beats are discarded.
- A packet cut by COUNT_RST or reset mid-packet restarts its PKT from 0. Its later beats form a new packet.
- Zero-length masks (TKEEP = 0) are accepted and contribute 0. TLAST on such a beat still latches and pulses.

## Timing
- Reset values: TREADY 0 while reset is high, 1 on the first cycle after. COUNT, LAST_PKT_COUNT, LAST_PKT_VALID and COUNT_BUSY are all 0.
- Latency: data accepted at edge k is in S1 after k, in S2 after k+1, and visible in COUNT after edge k+2.
- COUNT_BUSY goes high the cycle after edge k and low in the same cycle COUNT shows the final value (no further input assumed).
- LAST_PKT_VALID is high for exactly the cycle following edge k+2.
- Throughput: one beat plus one MMIO word per cycle, sustained.

## Configuration
- POPCOUNT_SATURATE_EN defined: COUNT and PKT/LAST_PKT_COUNT clamp at 2^COUNT_WIDTH-1 and hold until COUNT_RST or reset.
- POPCOUNT_SATURATE_EN undefined: both wrap modulo 2^COUNT_WIDTH.

## Test plan
- Reset: hold S_AXIS_ARESET 3 cycles, then release. Required: all outputs 0 during reset; TREADY 1 on the first cycle after release.
- Masked beat (DATA_WIDTH=64), TDATA=all ones, TKEEP=0x0F, TLAST=1. Required: COUNT=32 after edge k+2; LAST_PKT_COUNT=32 with a one-cycle pulse; COUNT_BUSY high for 2 cycles.
- Mixed, 4 back-to-back full beats of all ones plus WRITE_DATA=0x0000000F with WRITE_VALID on beat 2. Required: COUNT=260; LAST_PKT_COUNT=256; no TREADY drop.
- Two packets (beats of 3 ones, then 5 ones with TLAST, then 7 ones with TLAST). Required: LAST_PKT_COUNT=8, then 7; COUNT=15.
- COUNT_RST asserted the cycle after 2 beats are accepted. Required: TREADY 0 during COUNT_RST; COUNT=0; BUSY=0; no pulse; a subsequent beat of 4 ones gives COUNT=4.
- Overflow (COUNT_WIDTH=8, DATA_WIDTH=64), 5 full beats of all ones (320). Required: COUNT=64 without POPCOUNT_SATURATE_EN; COUNT=255 with it.
